float_to_fixed_denorm: RTL and testbench
========================================

Name: float_to_fixed_denorm

Overview:
- Pipelined denormalizer: converts a single-precision float (sign, 8-bit biased exponent, 23-bit fraction) into a 48-bit two's-complement fixed-point word.
- Performs the inverse of the normalization path: right or left barrel shift by an exponent-derived amount, then saturation and sign application.
- Sits after the float datapath (log/sqrt/cos stages) and feeds fixed-point noise samples to the output formatter.
- Valid/ready handshake on both sides; 3-stage pipeline.

Parameters:
- OUT_W, 48, fixed-point output width (including sign).
- FRAC_BITS, 32, number of fractional bits in the output; output format is Q(OUT_W-FRAC_BITS).FRAC_BITS.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  {sign[31], exp[30:23], frac[22:0]}.
- out_valid  output  1  out_data/flags valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  OUT_W  two's-complement fixed-point result.
- out_ovf  output  1  result saturated (overflow, inf or NaN).
- out_udf  output  1  nonzero input truncated to zero.

Behaviour:
- Reset: clock and reset ports are clk and rst; one clock, reset synchronous, active-high. While rst=1 at a clock edge: all stage valid bits, out_valid, out_data, out_ovf and out_udf clear to 0. In-flight samples are discarded. in_ready=1 during reset.
- Advance enable: en = !out_valid | out_ready. All three stages shift together when en=1 and hold when en=0. in_ready = en, combinational. A transfer occurs on in_valid&in_ready. Bubbles are not compressed.
- Latency: exactly 3 cycles from input accept to out_valid when out_ready is held at 1. Throughput is 1 sample per cycle.
- Stage 1 (classify):
  - mant = {1, frac} (24 bits).
  - Shift s = exp - BIAS + FRAC_BITS - 23, signed 10-bit. Default s = exp - 118.
  - exp=0: zero class (denormals flushed; udf=1 if frac!=0).
  - exp=255: sat class (ovf=1).
  - s >= OUT_W-24 (leading one at bit >= OUT_W-1): sat class, ovf=1.
  - s <= -24: zero class, udf=1.
- Stage 2 (shift):
  - s >= 0: mag = mant << s.
  - s < 0: mag = mant >> -s, truncation toward zero. No udf flag for partial truncation.
  - mag is OUT_W-1 bits.
- Stage 3 (sign/sat):
  - Zero class gives 0 regardless of sign; -0.0 gives 0.
  - Sat class gives +(2^(OUT_W-1)-1) = 48'h7FFF_FFFF_FFFF for sign=0. It gives -(2^(OUT_W-1)-1) = 48'h8000_0000_0001 for sign=1 (symmetric; 48'h8000_0000_0000 is never produced).
  - Otherwise the result is mag, negated (two's complement) when sign=1.
- Flags are registered alongside data and valid only when out_valid=1. ovf and udf are mutually exclusive.
- Output hold: while out_valid=1 and out_ready=0, out_data and flags are stable and in_ready=0.
- Simultaneous output and input transfer is allowed in the same cycle.

Test Plan:
- Reset mid-stream: rst pulsed with 3 samples in flight -> next cycle out_valid=0, out_data=0. No stale sample appears afterwards.
- Basic values, out_ready=1: 0x3F800000 (1.0) -> 48'h0001_0000_0000 three cycles later. 0xC0200000 (-2.5) -> 48'hFFFD_8000_0000, flags 0.
- Overflow: 0x47000000 (32768.0) -> 48'h7FFF_FFFF_FFFF, ovf=1. 0xFF800000 (-inf) -> 48'h8000_0000_0001, ovf=1. 0x7FC00000 (NaN) -> 48'h7FFF_FFFF_FFFF, ovf=1.
- Underflow boundary: 0x2F800000 (2^-32) -> 48'h0000_0000_0001, udf=0. 0x2F000000 (2^-33) -> 0, udf=1. 0x80000000 (-0.0) -> 0, flags 0.
- Backpressure: stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with out_ready low for cycles 4-7 -> in_ready=0 during the stall. Outputs arrive in order: 48'h1_0000_0000, 48'h2_0000_0000, 48'h3_0000_0000, 48'h4_0000_0000. No loss or duplication; out_data stable while stalled.
- Random: 10k random floats with random out_ready vs. reference model (real*2^32, truncate toward zero, symmetric saturate) -> bit-exact match on data and flags.

Source files
------------

// File: rtl/float_to_fixed_denorm.sv
// float_to_fixed_denorm: three-stage denormalizer from IEEE single precision
// to a symmetric-saturating two's-complement Q(OUT_W-FRAC_BITS).FRAC_BITS word.
// Stage 1 classifies and computes the shift, stage 2 barrel-shifts the
// mantissa, stage 3 applies saturation and sign.
module float_to_fixed_denorm #(
  parameter int OUT_W     = 48,
  parameter int FRAC_BITS = 32,
  parameter int BIAS      = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_udf
);

  localparam int MAG_W     = OUT_W - 1;
  localparam int SHIFT_OFS = BIAS - FRAC_BITS + 23;

  // Shift at which the leading one would land on the sign bit, and the shift
  // at which the whole mantissa falls below the least significant bit.
  localparam logic signed [9:0] SAT_S  = 10'(OUT_W - 24);
  localparam logic signed [9:0] ZERO_S = -10'sd24;

  localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_SAT  = 2'd2
  } cls_t;

  logic en;

  logic [7:0]        in_exp;
  logic [22:0]       in_frac;
  logic signed [9:0] in_shift;
  cls_t              in_cls;
  logic              in_ovf;
  logic              in_udf;

  logic              s1_valid;
  logic              s1_sign;
  cls_t              s1_cls;
  logic [23:0]       s1_mant;
  logic signed [9:0] s1_shift;
  logic              s1_ovf;
  logic              s1_udf;

  logic [MAG_W-1:0]  mant_ext;
  logic signed [9:0] neg_shift;
  logic [MAG_W-1:0]  s1_mag;

  logic              s2_valid;
  logic              s2_sign;
  cls_t              s2_cls;
  logic [MAG_W-1:0]  s2_mag;
  logic              s2_ovf;
  logic              s2_udf;

  logic [OUT_W-1:0]  s2_result;

  // The whole pipe moves as one unit; it only stalls when a result is stuck
  // at the output. Reset also reports ready so upstream never sees a stall.
  assign en       = !out_valid || out_ready;
  assign in_ready = en || rst;

  assign in_exp   = in_data[30:23];
  assign in_frac  = in_data[22:0];
  assign in_shift = $signed({2'b00, in_exp}) - 10'(SHIFT_OFS);

  // Classify the incoming float: flushed zero, saturating, or ordinary number.
  always_comb begin
    in_cls = CLS_NUM;
    in_ovf = 1'b0;
    in_udf = 1'b0;
    if (in_exp == 8'd0) begin
      in_cls = CLS_ZERO;
      in_udf = (in_frac != '0);
    end else if (in_exp == 8'hFF || in_shift >= SAT_S) begin
      in_cls = CLS_SAT;
      in_ovf = 1'b1;
    end else if (in_shift <= ZERO_S) begin
      in_cls = CLS_ZERO;
      in_udf = 1'b1;
    end
  end

  // Stage 1 register: classification, restored mantissa and shift amount.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_mant  <= '0;
      s1_shift <= '0;
      s1_ovf   <= 1'b0;
      s1_udf   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_data[31];
      s1_cls   <= in_cls;
      s1_mant  <= {1'b1, in_frac};
      s1_shift <= in_shift;
      s1_ovf   <= in_ovf;
      s1_udf   <= in_udf;
    end
  end

  assign mant_ext  = MAG_W'(s1_mant);
  assign neg_shift = -s1_shift;

  // Barrel shift; right shifts simply drop the low bits (truncate toward zero).
  always_comb begin
    s1_mag = '0;
    if (!s1_shift[9]) begin
      s1_mag = mant_ext << s1_shift;
    end else begin
      s1_mag = mant_ext >> neg_shift;
    end
  end

  // Stage 2 register: unsigned magnitude plus the carried class and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= CLS_ZERO;
      s2_mag   <= '0;
      s2_ovf   <= 1'b0;
      s2_udf   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls   <= s1_cls;
      s2_mag   <= s1_mag;
      s2_ovf   <= s1_ovf;
      s2_udf   <= s1_udf;
    end
  end

  // Apply symmetric saturation and sign; zeros ignore the sign so -0.0 maps to 0.
  always_comb begin
    s2_result = '0;
    case (s2_cls)
      CLS_SAT: s2_result = s2_sign ? NEG_SAT : POS_SAT;
      CLS_NUM: s2_result = s2_sign ? ('0 - {1'b0, s2_mag}) : {1'b0, s2_mag};
      default: s2_result = '0;
    endcase
  end

  // Output register: data and flags are only non-zero alongside a valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_udf   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_data  <= s2_valid ? s2_result : '0;
      out_ovf   <= s2_valid && s2_ovf;
      out_udf   <= s2_valid && s2_udf;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_denorm.sv
// tb_float_to_fixed_denorm: directed vector table, reset and backpressure
// sequences, and a randomized stream checked against a real-arithmetic model.
`timescale 1ns/1ps
module tb_float_to_fixed_denorm;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_ovf;
  logic        out_udf;

  int errors;
  int checks;

  typedef struct {
    logic [31:0] din;
    logic [47:0] dout;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[15];

  logic [31:0] src_q[$];
  logic [47:0] exp_d_q[$];
  logic [1:0]  exp_f_q[$];
  logic [47:0] got_q[$];

  float_to_fixed_denorm #(
    .OUT_W(48),
    .FRAC_BITS(32),
    .BIAS(127)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .out_udf(out_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something deadlocks outside the bounded loops.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one sample for a single cycle; caller guarantees in_ready is high.
  task automatic applyStimulus(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference: exact value of the float times 2^32, truncated toward zero,
  // saturated symmetrically at +/-(2^47-1). Flags are {ovf, udf}.
  function automatic void ref_model(input logic [31:0] f, output logic [47:0] d, output logic [1:0] fl);
    int     e;
    int     fr;
    real    mr;
    longint q;
    e  = int'(f[30:23]);
    fr = int'(f[22:0]);
    d  = '0;
    fl = 2'b00;
    if (e == 255) begin
      d  = f[31] ? 48'h8000_0000_0001 : 48'h7FFF_FFFF_FFFF;
      fl = 2'b10;
    end else begin
      if (e == 0) mr = 0.0;
      else        mr = (real'(fr) + 8388608.0) * (2.0 ** real'(e - 150 + 32));
      if (mr >= 2.0 ** 47) begin
        d  = f[31] ? 48'h8000_0000_0001 : 48'h7FFF_FFFF_FFFF;
        fl = 2'b10;
      end else begin
        q = longint'($floor(mr));
        d = f[31] ? 48'(-q) : 48'(q);
        if (q == 0 && (e != 0 || fr != 0)) fl = 2'b01;
      end
    end
  endfunction

  function automatic logic [31:0] rand_float();
    int          sel;
    logic [7:0]  e;
    logic [22:0] fr;
    sel = int'($urandom_range(0, 9));
    fr  = 23'($urandom);
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3, 4, 5, 6, 7: e = 8'($urandom_range(88, 148));
      default: e = 8'($urandom);
    endcase
    if (sel == 0 && $urandom_range(0, 1) == 0) fr = '0;
    return {1'($urandom), e, fr};
  endfunction

  // Streams src_q through the DUT with a scoreboard; mode 0 uses a fixed
  // stall window on cycles 4-7, mode 1 uses random valid/ready.
  task automatic run_stream(input int mode, input int max_cycles);
    int          idx;
    int          cyc;
    bit          held;
    logic [47:0] held_d;
    logic [1:0]  held_f;
    logic [47:0] rd;
    logic [1:0]  rf;
    idx  = 0;
    cyc  = 0;
    held = 1'b0;
    held_d = '0;
    held_f = '0;
    got_q.delete();
    exp_d_q.delete();
    exp_f_q.delete();
    while ((idx < src_q.size() || exp_d_q.size() != 0 || out_valid) && cyc < max_cycles) begin
      @(negedge clk);
      if (held) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_data", 64'(out_data), 64'(held_d));
        checkOutput("hold_flags", 64'({out_ovf, out_udf}), 64'(held_f));
      end
      if (mode == 0) out_ready = !(cyc >= 4 && cyc <= 7);
      else           out_ready = ($urandom_range(0, 9) < 7);
      if (idx < src_q.size()) begin
        in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = src_q[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          checkOutput("scoreboard_has_entry", 64'(exp_d_q.size() != 0), 64'd1);
          if (exp_d_q.size() != 0) begin
            checkOutput("stream_data", 64'(out_data), 64'(exp_d_q[0]));
            checkOutput("stream_flags", 64'({out_ovf, out_udf}), 64'(exp_f_q[0]));
            void'(exp_d_q.pop_front());
            void'(exp_f_q.pop_front());
          end
          got_q.push_back(out_data);
        end else begin
          held   = 1'b1;
          held_d = out_data;
          held_f = {out_ovf, out_udf};
          checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        end
      end
      if (in_valid && in_ready) begin
        ref_model(in_data, rd, rf);
        exp_d_q.push_back(rd);
        exp_f_q.push_back(rf);
        idx++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_all_sent", 64'(idx), 64'(src_q.size()));
    checkOutput("stream_drained", 64'(exp_d_q.size()), 64'd0);
  endtask

  initial begin
    logic [47:0] bp_exp[4];
    int          stale;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    vecs[0]  = '{32'h3F80_0000, 48'h0001_0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'hC020_0000, 48'hFFFD_8000_0000, 1'b0, 1'b0};
    vecs[2]  = '{32'h4700_0000, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{32'hFF80_0000, 48'h8000_0000_0001, 1'b1, 1'b0};
    vecs[4]  = '{32'h7FC0_0000, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[5]  = '{32'h2F80_0000, 48'h0000_0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{32'h2F00_0000, 48'h0000_0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h8000_0000, 48'h0000_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h46FF_FFFF, 48'h7FFF_FF80_0000, 1'b0, 1'b0};
    vecs[9]  = '{32'hC6FF_FFFF, 48'h8000_0080_0000, 1'b0, 1'b0};
    vecs[10] = '{32'hAF80_0000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0001, 48'h0000_0000_0000, 1'b0, 1'b1};
    vecs[12] = '{32'hC700_0000, 48'h8000_0000_0001, 1'b1, 1'b0};
    vecs[13] = '{32'h2FC0_0000, 48'h0000_0000_0001, 1'b0, 1'b0};
    vecs[14] = '{32'h4120_0000, 48'h000A_0000_0000, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Directed vectors with exact 3-cycle latency.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].din);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_not_early", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].dout));
      checkOutput($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_udf", i), 64'(out_udf), 64'(vecs[i].udf));
    end

    // Reset with three samples in flight, output stalled during reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h4700_0000;
    @(negedge clk);
    in_data  = 32'h3F80_0000;
    @(negedge clk);
    in_data  = 32'hC020_0000;
    @(negedge clk);
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_data", 64'(out_data), 64'd0);
    checkOutput("midreset_out_ovf", 64'(out_ovf), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("midreset_no_stale", 64'(stale), 64'd0);

    // Backpressure: four samples with out_ready low on cycles 4-7.
    src_q.delete();
    src_q.push_back(32'h3F80_0000);
    src_q.push_back(32'h4000_0000);
    src_q.push_back(32'h4040_0000);
    src_q.push_back(32'h4080_0000);
    bp_exp[0] = 48'h0001_0000_0000;
    bp_exp[1] = 48'h0002_0000_0000;
    bp_exp[2] = 48'h0003_0000_0000;
    bp_exp[3] = 48'h0004_0000_0000;
    run_stream(0, 100);
    checkOutput("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_order%0d", i),
                  (i < got_q.size()) ? 64'(got_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF,
                  64'(bp_exp[i]));
    end

    // Random stream against the real-arithmetic reference.
    src_q.delete();
    for (int i = 0; i < 10000; i++) src_q.push_back(rand_float());
    run_stream(1, 60000);
    checkOutput("rand_count", 64'(got_q.size()), 64'd10000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
